// File: rtl/nvdla_ssync_hs_pkg.sv
// Shared types and constants for the synchronized 4-phase handshake receiver.
package nvdla_ssync_hs_pkg;

    typedef enum logic [1:0] {
        WLOW  = 2'd0,
        IDLE  = 2'd1,
        VALID = 2'd2,
        ACK   = 2'd3
    } state_e;

    localparam int ERR_TMO   = 0;
    localparam int ERR_PROTO = 1;

    localparam int CNT_W_DEF   = 16;
    localparam int TMO_W_DEF   = 12;
    localparam int TMO_MAX_DEF = 4095;

endpackage

// File: rtl/nvdla_sat_cnt.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module nvdla_sat_cnt #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/nvdla_ssync_hs_rcv.sv
// Destination-side receiver: turns each synchronized req level into one
// valid/ready event, returns ack, and keeps debug counters and error flags.
module nvdla_ssync_hs_rcv
    import nvdla_ssync_hs_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int TMO_MAX = TMO_MAX_DEF
) (
    input  logic             o_clk,
    input  logic             o_rst,
    input  logic             req_sync,
    output logic             ack_o,
    output logic             evt_pvld,
    input  logic             evt_prdy,
    output logic [CNT_W-1:0] evt_cnt,
    input  logic             evt_cnt_clr,
    output logic [1:0]       err_o,
    input  logic             err_clr
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_MAX);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_MAX - 1);

    state_e           state;
    state_e           state_nxt;
    logic             hs;
    logic             tmo_inc;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       err_set;

    assign hs      = evt_pvld & evt_prdy;
    assign tmo_inc = (state == ACK) & req_sync;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        err_set   = '0;
        case (state)
            WLOW:    if (!req_sync) state_nxt = IDLE;
            IDLE:    if (req_sync)  state_nxt = VALID;
            VALID: begin
                if (hs) state_nxt = ACK;
                err_set[ERR_PROTO] = ~req_sync;
            end
            ACK: begin
                if (!req_sync) state_nxt = IDLE;
                // Fires on the cycle the counter reaches the limit and keeps
                // firing while it sits there, so a clear cannot hide it.
                err_set[ERR_TMO] = req_sync && (tmo_cnt >= TMO_LAST);
            end
            default: state_nxt = WLOW;
        endcase
    end

    // Outputs are decoded from the next state so each one is a plain flop.
    always_ff @(posedge o_clk) begin
        if (o_rst) begin
            state    <= WLOW;
            ack_o    <= 1'b0;
            evt_pvld <= 1'b0;
            err_o    <= '0;
        end else begin
            state    <= state_nxt;
            ack_o    <= (state_nxt == ACK);
            evt_pvld <= (state_nxt == VALID);
            err_o    <= err_set | (err_o & ~{2{err_clr}});
        end
    end

    nvdla_sat_cnt #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_evt_cnt (
        .clk (o_clk),
        .rst (o_rst),
        .clr (evt_cnt_clr),
        .inc (hs),
        .cnt (evt_cnt)
    );

    // Cleared by the handshake that moves the FSM into ACK.
    nvdla_sat_cnt #(
        .W   (TMO_W),
        .MAX (TMO_LIMIT)
    ) u_tmo_cnt (
        .clk (o_clk),
        .rst (o_rst),
        .clr (hs),
        .inc (tmo_inc),
        .cnt (tmo_cnt)
    );

endmodule

// File: tb/tb_nvdla_ssync_hs_rcv.sv
// Directed scoreboard bench: stimulus queues timed expectations, monitors compare.
module tb_nvdla_ssync_hs_rcv;

    localparam int CNT_W   = 4;
    localparam int TMO_W   = 12;
    localparam int TMO_MAX = 8;

    logic             o_clk;
    logic             o_rst;
    logic             req_sync;
    logic             ack_o;
    logic             evt_pvld;
    logic             evt_prdy;
    logic [CNT_W-1:0] evt_cnt;
    logic             evt_cnt_clr;
    logic [1:0]       err_o;
    logic             err_clr;

    nvdla_ssync_hs_rcv #(
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) dut (
        .o_clk       (o_clk),
        .o_rst       (o_rst),
        .req_sync    (req_sync),
        .ack_o       (ack_o),
        .evt_pvld    (evt_pvld),
        .evt_prdy    (evt_prdy),
        .evt_cnt     (evt_cnt),
        .evt_cnt_clr (evt_cnt_clr),
        .err_o       (err_o),
        .err_clr     (err_clr)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic       ack;
        logic       pvld;
        logic [3:0] cnt;
        logic [1:0] err;
    } snap_t;

    snap_t      exp_q[$];
    int         hs_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] e_cnt = '0;
    logic [1:0] e_err = '0;

    initial begin
        o_clk = 1'b0;
        forever #5 o_clk = ~o_clk;
    end

    always @(posedge o_clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge o_clk);
            #1;
        end
    endtask

    task automatic expect_at(input int delta, input string name, input logic ack,
                             input logic pvld, input logic [3:0] cnt, input logic [1:0] err);
        snap_t s;
        s.cyc  = cyc + delta;
        s.name = name;
        s.ack  = ack;
        s.pvld = pvld;
        s.cnt  = cnt;
        s.err  = err;
        exp_q.push_back(s);
    endtask

    task automatic expect_hs(input int delta);
        hs_q.push_back(cyc + delta);
    endtask

    // Snapshot monitor: compares every expectation whose cycle has arrived.
    always @(negedge o_clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                if (exp_q[i].cyc < cyc) begin
                    check({exp_q[i].name, "_missed"}, 32'd1, 32'd0);
                end else begin
                    check({exp_q[i].name, "_ack"},  32'(ack_o),    32'(exp_q[i].ack));
                    check({exp_q[i].name, "_pvld"}, 32'(evt_pvld), 32'(exp_q[i].pvld));
                    check({exp_q[i].name, "_cnt"},  32'(evt_cnt),  32'(exp_q[i].cnt));
                    check({exp_q[i].name, "_err"},  32'(err_o),    32'(exp_q[i].err));
                end
                exp_q.delete(i);
            end
        end
    end

    // Handshake monitor: each delivered event must match a queued expectation.
    always @(negedge o_clk) begin
        if (evt_pvld === 1'b1 && evt_prdy === 1'b1) begin
            if (hs_q.size() == 0) begin
                check("unexpected_handshake", 32'd1, 32'd0);
            end else begin
                check("handshake_cycle", 32'(cyc), 32'(hs_q.pop_front()));
            end
        end
    end

    // One full transaction starting from IDLE: rise, wait, handshake, hold, release.
    task automatic txn(input int wait_cyc, input int hold, input logic clr_hs);
        req_sync = 1'b1;
        evt_prdy = 1'b0;
        expect_at(1, "txn_rise", 1'b0, 1'b1, e_cnt, e_err);
        step(1);
        for (int i = 0; i < wait_cyc; i++) begin
            expect_at(1, "txn_wait", 1'b0, 1'b1, e_cnt, e_err);
            step(1);
        end
        evt_prdy    = 1'b1;
        evt_cnt_clr = clr_hs;
        expect_hs(0);
        e_cnt = clr_hs ? 4'd1 : ((e_cnt == 4'hf) ? 4'hf : e_cnt + 4'd1);
        expect_at(1, "txn_ack", 1'b1, 1'b0, e_cnt, e_err);
        step(1);
        evt_prdy    = 1'b0;
        evt_cnt_clr = 1'b0;
        for (int i = 0; i < hold; i++) begin
            expect_at(1, "txn_hold", 1'b1, 1'b0, e_cnt, e_err);
            step(1);
        end
        req_sync = 1'b0;
        expect_at(1, "txn_release", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
    endtask

    initial begin
        o_rst       = 1'b1;
        req_sync    = 1'b1;
        evt_prdy    = 1'b0;
        evt_cnt_clr = 1'b0;
        err_clr     = 1'b0;
        step(2);
        expect_at(0, "reset", 1'b0, 1'b0, 4'd0, 2'd0);

        // Stale high req after reset must not produce an event.
        o_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_at(1, "wlow_hold", 1'b0, 1'b0, 4'd0, 2'd0);
            step(1);
        end
        req_sync = 1'b0;
        expect_at(1, "wlow_exit", 1'b0, 1'b0, 4'd0, 2'd0);
        step(1);
        txn(0, 2, 1'b0);

        // Single transaction with ready high, then consumer backpressure.
        txn(0, 5, 1'b0);
        txn(7, 1, 1'b0);

        // Timeout: req held high in ACK.
        req_sync = 1'b1;
        expect_at(1, "tmo_rise", 1'b0, 1'b1, e_cnt, e_err);
        step(1);
        evt_prdy = 1'b1;
        expect_hs(0);
        e_cnt = e_cnt + 4'd1;
        expect_at(1, "tmo_ack", 1'b1, 1'b0, e_cnt, e_err);
        step(1);
        evt_prdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k + 1 >= TMO_MAX) e_err[0] = 1'b1;
            expect_at(1, "tmo_hold", 1'b1, 1'b0, e_cnt, e_err);
            step(1);
        end
        err_clr = 1'b1;
        expect_at(1, "tmo_clr_set_wins", 1'b1, 1'b0, e_cnt, e_err);
        step(1);
        err_clr  = 1'b0;
        req_sync = 1'b0;
        expect_at(1, "tmo_release", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        err_clr = 1'b1;
        e_err   = 2'b00;
        expect_at(1, "tmo_err_clr", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        err_clr = 1'b0;

        // Protocol error: req drops while the event is still pending.
        req_sync = 1'b1;
        expect_at(1, "proto_rise", 1'b0, 1'b1, e_cnt, e_err);
        step(1);
        req_sync = 1'b0;
        e_err[1] = 1'b1;
        expect_at(1, "proto_flag", 1'b0, 1'b1, e_cnt, e_err);
        step(1);
        evt_prdy = 1'b1;
        expect_hs(0);
        e_cnt = e_cnt + 4'd1;
        expect_at(1, "proto_ack", 1'b1, 1'b0, e_cnt, e_err);
        step(1);
        evt_prdy = 1'b0;
        expect_at(1, "proto_idle", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        err_clr = 1'b1;
        e_err   = 2'b00;
        expect_at(1, "proto_err_clr", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        err_clr = 1'b0;

        // Drive the event counter into saturation, then the clear cases.
        for (int t = 0; t < 12; t++) txn(0, 0, 1'b0);
        txn(1, 0, 1'b1);
        evt_cnt_clr = 1'b1;
        e_cnt       = 4'd0;
        expect_at(1, "cnt_clr_alone", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        evt_cnt_clr = 1'b0;
        txn(0, 0, 1'b0);

        // Reset while VALID aborts the event.
        req_sync = 1'b1;
        expect_at(1, "abort_rise", 1'b0, 1'b1, e_cnt, e_err);
        step(1);
        o_rst = 1'b1;
        e_cnt = 4'd0;
        e_err = 2'b00;
        expect_at(1, "abort_reset", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        o_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expect_at(1, "abort_wlow", 1'b0, 1'b0, e_cnt, e_err);
            step(1);
        end
        req_sync = 1'b0;
        expect_at(1, "abort_wlow_exit", 1'b0, 1'b0, e_cnt, e_err);
        step(1);
        txn(2, 1, 1'b0);

        step(3);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("hs_q_drained", 32'(hs_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nvdla_ssync_hs_rcv.md
Name: nvdla_ssync_hs_rcv

Overview:
Destination-domain receiver for a 4-phase req/ack handshake whose request arrives through the 3-flop strict synchronizer.
- Converts each synchronized request level into exactly one valid/ready event for local logic.
- Drives the ack level that returns to the source domain through a reverse synchronizer.
- Keeps a saturating event count and sticky protocol/timeout error flags for debug status.

Parameters:
CNT_W, 16, width of delivered-event counter
TMO_W, 12, width of ack-phase timeout counter
TMO_MAX, 4095, cycles in ACK with req still high before timeout error (1..2^TMO_W-1)

Ports:
o_clk  in  1  destination clock; the only clock
o_rst  in  1  reset, synchronous, active-high
req_sync  in  1  request level, already 3-flop synchronized into o_clk
ack_o  out  1  ack level returned to source (registered)
evt_pvld  out  1  event valid to local consumer (registered)
evt_prdy  in  1  consumer ready
evt_cnt  out  CNT_W  delivered events, saturating
evt_cnt_clr  in  1  synchronous clear of evt_cnt
err_o  out  2  sticky errors: [0]=timeout, [1]=protocol
err_clr  in  1  synchronous clear of err_o

Behaviour:
- Reset (o_rst=1 at a rising o_clk edge):
  - state=WLOW; ack_o=0, evt_pvld=0, evt_cnt=0, err_o=0; timeout counter=0.
  - Reset asserted mid-transaction aborts it with the same result; no event is delivered for the aborted request.
- States (2-bit encoding) WLOW/IDLE/VALID/ACK; every output is a flop, no combinational path in to out.
- WLOW:
  - ack_o=0; wait for req_sync==0, then IDLE next cycle.
  - Prevents a stale high req left over from before reset producing a spurious event.
- IDLE:
  - ack_o=0, evt_pvld=0.
  - req_sync==1 in cycle N -> VALID with evt_pvld=1 from cycle N+1.
- VALID:
  - evt_pvld held at 1 until the cycle where evt_pvld&evt_prdy; that is the handshake cycle.
  - Handshake in cycle M -> ACK; ack_o=1 and evt_pvld=0 from M+1.
  - req_sync==0 while in VALID: set err_o[1] the next cycle. The event is still delivered (evt_pvld not withdrawn) and the FSM continues normally.
- ACK:
  - ack_o=1. Timeout counter clears on entry and increments each cycle req_sync==1.
  - Counter reaches TMO_MAX: set err_o[0]; counter holds at TMO_MAX; state stays ACK with ack_o held high.
  - req_sync==0 -> IDLE; ack_o=0 from the next cycle.
  - Minimum full transaction: req rise to ack fall is 3 cycles plus handshake wait plus source release time.
- evt_cnt:
  - +1 on each handshake cycle; saturates at 2^CNT_W-1 (no wrap).
  - evt_cnt_clr and handshake in the same cycle -> evt_cnt=1 (clear, then count).
  - evt_cnt_clr alone -> 0.
- err_o:
  - Bits only set by the events above; cleared by err_clr.
  - Set and err_clr in the same cycle -> set wins (bit=1).
- Back-to-back: a new req rise is only accepted after the ACK->IDLE transition. A req that is still high on entering IDLE starts the next event.

Decomposition:
- Package nvdla_ssync_hs_pkg: state enum (WLOW, IDLE, VALID, ACK), error-bit index constants (ERR_TMO=0, ERR_PROTO=1), default widths.
- One sub-module nvdla_sat_cnt (params W, MAX; inputs clr, inc; clear-then-increment, saturating), instanced for evt_cnt (MAX=all ones) and the timeout counter (MAX=TMO_MAX).

Test Plan:
- Reset release with req_sync=1 held 5 cycles -> state stays WLOW, evt_pvld=0, ack_o=0; req low then high again -> evt_pvld=1 one cycle after the rise.
- Single transaction with evt_prdy=1: req rise at cycle 10 -> evt_pvld=1 at cycle 11, ack_o=1 at 12; req fall at 20 -> ack_o=0 at 21; evt_cnt=1, err_o=0.
- Consumer backpressure: evt_prdy low 7 cycles -> evt_pvld held high 8 cycles, ack_o rises one cycle after prdy rises, evt_cnt increments once.
- Timeout with TMO_MAX=8: req held high after ack -> err_o[0]=1 after 8 cycles in ACK; err_clr with req still high -> err_o[0] stays 1 (set wins); req fall then err_clr -> err_o=0.
- Protocol error: req drops while evt_pvld=1, prdy=0 -> err_o[1]=1 next cycle; event still delivered once prdy rises; ack_o pulses one cycle, then IDLE.
- Counter edges with CNT_W=4: 16 transactions -> evt_cnt=15 saturated; evt_cnt_clr coincident with handshake -> evt_cnt=1; reset asserted in VALID -> all outputs 0, state WLOW.
